// File: rtl/fifo_stream_averager_pkg.sv
// Shared types and constants for the FIFO stream averager: FSM state encoding,
// accumulator width and the round-half-up constant.
package avg_pkg;

    typedef enum logic [1:0] {
        ST_ACCUM = 2'd0,
        ST_ROUND = 2'd1,
        ST_HOLD  = 2'd2
    } avg_state_e;

    // Summing 2^log2_n samples of width bits never needs more than width+log2_n bits.
    function automatic int sum_width(input int width, input int log2_n);
        return width + log2_n;
    endfunction

    // Half of one LSB after the final shift; zero when no division takes place.
    function automatic int round_const(input int log2_n);
        if (log2_n > 0) begin
            return 1 << (log2_n - 1);
        end else begin
            return 0;
        end
    endfunction

endpackage

// File: rtl/avg_round_shift.sv
// Combinational divide-by-2^LOG2_N with round-half-up and saturation to the
// sample width.
module avg_round_shift
    import avg_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int LOG2_N = 3
) (
    input  logic [sum_width(WIDTH, LOG2_N)-1:0] sum,
    output logic [WIDTH-1:0]                    avg
);

    localparam int          SW = sum_width(WIDTH, LOG2_N);
    localparam logic [SW:0] RC = (SW+1)'(round_const(LOG2_N));

    logic [SW:0] rounded;
    logic [SW:0] shifted;

    // One spare bit keeps the carry from the rounding add; if it survives the
    // shift the true average is 2^WIDTH and is clamped to all ones.
    always_comb begin
        rounded = {1'b0, sum} + RC;
        shifted = rounded >> LOG2_N;
        if (|shifted[SW:WIDTH]) begin
            avg = '1;
        end else begin
            avg = shifted[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/fifo_stream_averager.sv
// Drains a FIFO, averages blocks of 2^LOG2_N samples and presents each rounded
// average on a valid/ack output held until accepted.
module fifo_stream_averager
    import avg_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int LOG2_N = 3
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             ENABLE,
    input  logic             CLEAR,
    input  logic             FIFO_READY,
    input  logic [WIDTH-1:0] FIFO_DATA,
    output logic             FIFO_ACK,
    output logic             AVG_VALID,
    output logic [WIDTH-1:0] AVG_DATA,
    input  logic             AVG_ACK,
    output logic             BUSY,
    output avg_state_e       STATE_DBG
);

    // Handshakes: FIFO side pops the head on any edge where FIFO_ACK=1 (only
    // offered while FIFO_READY=1); output side transfers on any edge where
    // AVG_VALID=1 and AVG_ACK=1, with AVG_DATA stable while AVG_VALID=1.

    localparam int                SW   = sum_width(WIDTH, LOG2_N);
    localparam int                CW   = (LOG2_N > 0) ? LOG2_N : 1;
    localparam int                N    = 1 << LOG2_N;
    localparam logic [CW-1:0]     LAST = CW'(N - 1);

    avg_state_e       state;
    avg_state_e       state_next;
    logic [SW-1:0]    sum;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] rounded_avg;
    logic             fifo_ack;
    logic             last_sample;

    avg_round_shift #(
        .WIDTH (WIDTH),
        .LOG2_N(LOG2_N)
    ) u_round (
        .sum(sum),
        .avg(rounded_avg)
    );

    assign last_sample = (count == LAST);

    always_comb begin
        state_next = state;
        fifo_ack   = 1'b0;
        case (state)
            ST_ACCUM: begin
                fifo_ack = ENABLE & FIFO_READY & ~CLEAR & RESET_N;
                if (fifo_ack && last_sample) begin
                    state_next = ST_ROUND;
                end
            end
            ST_ROUND: begin
                state_next = ST_HOLD;
            end
            ST_HOLD: begin
                if (AVG_ACK) begin
                    state_next = ST_ACCUM;
                end
            end
            default: begin
                state_next = ST_ACCUM;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N || CLEAR) begin
            state <= ST_ACCUM;
        end else begin
            state <= state_next;
        end
    end

    // Datapath follows the registered state; ROUND lasts exactly one cycle.
    always_ff @(posedge CLK) begin
        if (!RESET_N || CLEAR) begin
            sum       <= '0;
            count     <= '0;
            AVG_VALID <= 1'b0;
            AVG_DATA  <= '0;
        end else begin
            case (state)
                ST_ACCUM: begin
                    if (fifo_ack) begin
                        sum <= sum + SW'(FIFO_DATA);
                        if (last_sample) begin
                            count <= '0;
                        end else begin
                            count <= count + 1'b1;
                        end
                    end
                end
                ST_ROUND: begin
                    AVG_DATA  <= rounded_avg;
                    AVG_VALID <= 1'b1;
                    sum       <= '0;
                end
                ST_HOLD: begin
                    if (AVG_ACK) begin
                        AVG_VALID <= 1'b0;
                    end
                end
                default: begin
                    AVG_VALID <= 1'b0;
                end
            endcase
        end
    end

    assign FIFO_ACK  = fifo_ack;
    assign BUSY      = (count != '0) | (state != ST_ACCUM);
    assign STATE_DBG = state;

endmodule

// File: tb/tb_fifo_stream_averager.sv
// Directed bench for fifo_stream_averager (WIDTH=8, LOG2_N=3) with a queue-based
// FIFO model, a table of block vectors and hand-written corner sequences.
module tb_fifo_stream_averager;
    import avg_pkg::*;

    logic       CLK = 1'b0;
    logic       RESET_N;
    logic       ENABLE;
    logic       CLEAR;
    logic       FIFO_READY;
    logic [7:0] FIFO_DATA;
    logic       FIFO_ACK;
    logic       AVG_VALID;
    logic [7:0] AVG_DATA;
    logic       AVG_ACK;
    logic       BUSY;
    avg_state_e STATE_DBG;

    logic [7:0] fifo_q[$];
    logic [7:0] exp_q[$];
    logic       ready_en;
    int         checks;
    int         errors;

    typedef struct packed {
        logic [7:0][7:0] s;
        logic [7:0]      avg;
    } vec_t;

    vec_t vecs[6];

    fifo_stream_averager #(
        .WIDTH (8),
        .LOG2_N(3)
    ) dut (
        .CLK       (CLK),
        .RESET_N   (RESET_N),
        .ENABLE    (ENABLE),
        .CLEAR     (CLEAR),
        .FIFO_READY(FIFO_READY),
        .FIFO_DATA (FIFO_DATA),
        .FIFO_ACK  (FIFO_ACK),
        .AVG_VALID (AVG_VALID),
        .AVG_DATA  (AVG_DATA),
        .AVG_ACK   (AVG_ACK),
        .BUSY      (BUSY),
        .STATE_DBG (STATE_DBG)
    );

    // ---------------- clock ----------------
    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not end, act=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: act=%0d exp=%0d @%0t", name, act, exp, $time);
        end
    endtask

    // Called at a falling edge: drives the FIFO model, observes FIFO_ACK, then
    // passes one rising edge and returns at the next falling edge.
    task automatic tick(output logic acked);
        FIFO_READY = ready_en && (fifo_q.size() != 0);
        FIFO_DATA  = (fifo_q.size() != 0) ? fifo_q[0] : 8'd0;
        #1;
        acked = FIFO_ACK;
        checks++;
        if (FIFO_ACK && !(FIFO_READY && ENABLE && !CLEAR && RESET_N)) begin
            errors++;
            $display("FAIL ack_gate: act=1 exp=0 (ready=%0b en=%0b clr=%0b rst_n=%0b) @%0t",
                     FIFO_READY, ENABLE, CLEAR, RESET_N, $time);
        end
        if (acked) begin
            void'(fifo_q.pop_front());
        end
        @(negedge CLK);
    endtask

    task automatic push_block(input logic [7:0][7:0] s, input logic [7:0] avg);
        for (int j = 0; j < 8; j++) begin
            fifo_q.push_back(s[j]);
        end
        exp_q.push_back(avg);
    endtask

    // Ticks until AVG_VALID (bounded) and scores the result against exp_q.
    task automatic wait_result(output int lat);
        logic a;
        logic found;
        logic [7:0] exp;
        lat   = 0;
        found = 1'b0;
        for (int k = 0; k < 60 && !found; k++) begin
            tick(a);
            lat++;
            if (AVG_VALID) found = 1'b1;
        end
        if (!found) begin
            checks++;
            errors++;
            $display("FAIL result_timeout: act=no_valid exp=valid @%0t", $time);
        end else if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result: act=%0d exp=none @%0t", AVG_DATA, $time);
        end else begin
            exp = exp_q.pop_front();
            check("avg_data", 32'(AVG_DATA), 32'(exp));
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic a;
        int   lat;
        int   acks;
        logic done;

        RESET_N    = 1'b0;
        ENABLE     = 1'b1;
        CLEAR      = 1'b0;
        FIFO_READY = 1'b0;
        FIFO_DATA  = 8'd0;
        AVG_ACK    = 1'b1;
        ready_en   = 1'b1;
        checks     = 0;
        errors     = 0;

        vecs[0].s = {8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};  vecs[0].avg = 8'd5;
        vecs[1].s = {8{8'd255}};                                       vecs[1].avg = 8'd255;
        vecs[2].s = {8'd4, {7{8'd0}}};                                 vecs[2].avg = 8'd1;
        vecs[3].s = {8'd3, {7{8'd0}}};                                 vecs[3].avg = 8'd0;
        vecs[4].s = {8'd8, {7{8'd7}}};                                 vecs[4].avg = 8'd7;
        vecs[5].s = {{7{8'd0}}, 8'd100};                               vecs[5].avg = 8'd13;

        @(negedge CLK);

        // Reset: FIFO non-empty but no pops, all outputs zero.
        fifo_q.push_back(8'hAA);
        for (int i = 0; i < 3; i++) begin
            tick(a);
            check("reset_fifo_ack", 32'(a), 32'd0);
        end
        check("reset_avg_valid", 32'(AVG_VALID), 32'd0);
        check("reset_avg_data", 32'(AVG_DATA), 32'd0);
        check("reset_busy", 32'(BUSY), 32'd0);
        check("reset_state", 32'(STATE_DBG), 32'(ST_ACCUM));
        fifo_q.delete();
        RESET_N = 1'b1;

        // Test 1: eight consecutive pops, valid two edges after the 8th, one cycle wide.
        push_block(vecs[0].s, vecs[0].avg);
        for (int i = 0; i < 8; i++) begin
            tick(a);
            check("t1_consecutive_ack", 32'(a), 32'd1);
        end
        check("t1_valid_after_1_edge", 32'(AVG_VALID), 32'd0);
        check("t1_state_round", 32'(STATE_DBG), 32'(ST_ROUND));
        tick(a);
        check("t1_valid_after_2_edges", 32'(AVG_VALID), 32'd1);
        check("t1_avg", 32'(AVG_DATA), 32'(exp_q.pop_front()));
        tick(a);
        check("t1_valid_one_cycle", 32'(AVG_VALID), 32'd0);
        check("t1_avg_kept", 32'(AVG_DATA), 32'd5);

        // Table: full blocks with AVG_ACK tied high.
        for (int i = 0; i < 6; i++) begin
            push_block(vecs[i].s, vecs[i].avg);
            wait_result(lat);
            check("tbl_latency", 32'(lat), 32'd9);
            tick(a);
            check("tbl_valid_drop", 32'(AVG_VALID), 32'd0);
            check("tbl_busy_idle", 32'(BUSY), 32'd0);
        end

        // Test 3: backpressure in HOLD for 10 cycles with a second block queued.
        AVG_ACK = 1'b0;
        push_block({8{8'd10}}, 8'd10);
        push_block({8{8'd10}}, 8'd10);
        wait_result(lat);
        for (int i = 0; i < 10; i++) begin
            tick(a);
            check("t3_hold_no_ack", 32'(a), 32'd0);
            check("t3_hold_valid", 32'(AVG_VALID), 32'd1);
            check("t3_hold_data", 32'(AVG_DATA), 32'd10);
        end
        check("t3_hold_busy", 32'(BUSY), 32'd1);
        AVG_ACK = 1'b1;
        tick(a);
        check("t3_release_valid", 32'(AVG_VALID), 32'd0);
        wait_result(lat);
        check("t3_second_latency", 32'(lat), 32'd9);
        tick(a);

        // Test 4: READY toggling every cycle and ENABLE low for 5 cycles.
        push_block(vecs[0].s, vecs[0].avg);
        acks = 0;
        done = 1'b0;
        for (int i = 0; i < 80 && !done; i++) begin
            ready_en = (i % 2 == 0);
            ENABLE   = !(i >= 6 && i < 11);
            tick(a);
            if (!ENABLE || !ready_en) check("t4_no_ack_when_stalled", 32'(a), 32'd0);
            if (a) acks++;
            if (AVG_VALID) done = 1'b1;
        end
        check("t4_done", 32'(done), 32'd1);
        check("t4_ack_count", 32'(acks), 32'd8);
        check("t4_avg", 32'(AVG_DATA), 32'(exp_q.pop_front()));
        ENABLE   = 1'b1;
        ready_en = 1'b1;
        tick(a);

        // Test 5: reset mid-block.
        push_block(vecs[0].s, vecs[0].avg);
        for (int i = 0; i < 4; i++) tick(a);
        check("t5_busy_partial", 32'(BUSY), 32'd1);
        RESET_N = 1'b0;
        tick(a);
        check("t5_reset_no_ack", 32'(a), 32'd0);
        check("t5_reset_valid", 32'(AVG_VALID), 32'd0);
        check("t5_reset_data", 32'(AVG_DATA), 32'd0);
        check("t5_reset_busy", 32'(BUSY), 32'd0);
        fifo_q.delete();
        RESET_N = 1'b1;
        fifo_q.push_back(8'd1); fifo_q.push_back(8'd2); fifo_q.push_back(8'd3); fifo_q.push_back(8'd4);
        fifo_q.push_back(8'd5); fifo_q.push_back(8'd6); fifo_q.push_back(8'd7); fifo_q.push_back(8'd8);
        wait_result(lat);
        check("t5_latency", 32'(lat), 32'd9);
        tick(a);

        // Test 6a: CLEAR while a result is held.
        AVG_ACK = 1'b0;
        push_block(vecs[4].s, vecs[4].avg);
        wait_result(lat);
        push_block(vecs[0].s, vecs[0].avg);
        void'(exp_q.pop_back());
        CLEAR = 1'b1;
        tick(a);
        check("t6a_clear_no_ack", 32'(a), 32'd0);
        check("t6a_valid_dropped", 32'(AVG_VALID), 32'd0);
        check("t6a_data_cleared", 32'(AVG_DATA), 32'd0);
        check("t6a_busy", 32'(BUSY), 32'd0);
        CLEAR   = 1'b0;
        AVG_ACK = 1'b1;
        exp_q.push_back(8'd5);
        wait_result(lat);
        check("t6a_latency", 32'(lat), 32'd9);
        tick(a);

        // Test 6b: CLEAR after three samples; partial sum must be discarded.
        fifo_q.push_back(8'd50); fifo_q.push_back(8'd50); fifo_q.push_back(8'd50);
        push_block(vecs[0].s, vecs[0].avg);
        for (int i = 0; i < 3; i++) tick(a);
        check("t6b_busy_partial", 32'(BUSY), 32'd1);
        CLEAR = 1'b1;
        tick(a);
        check("t6b_clear_no_ack", 32'(a), 32'd0);
        check("t6b_fifo_intact", 32'(fifo_q.size()), 32'd8);
        check("t6b_busy", 32'(BUSY), 32'd0);
        check("t6b_valid", 32'(AVG_VALID), 32'd0);
        CLEAR = 1'b0;
        wait_result(lat);
        check("t6b_latency", 32'(lat), 32'd9);
        tick(a);
        check("t6b_idle_busy", 32'(BUSY), 32'd0);
        check("exp_q_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
